// File: rtl/stack_queue_pkg.sv
// Shared defaults and mode encodings for the combined stack/queue store.
package stack_queue_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int DEPTH_DEFAULT = 16;
  localparam int PTR_W         = $clog2(DEPTH_DEFAULT);

  localparam logic MODE_STACK = 1'b0;
  localparam logic MODE_QUEUE = 1'b1;

endpackage

// File: rtl/stack_queue_store.sv
// Circular-buffer store that behaves as a LIFO or FIFO depending on stackQueue.
// The newest and oldest entries are always visible, so the mode can change at any time.
module stack_queue_store
  import stack_queue_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     stackQueue,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         stack_out,
  output logic [WIDTH-1:0]         queue_out,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    tail_prev;
  logic [PW:0]      count_q;
  logic             do_push;
  logic             do_pop;
  logic             reject;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (PW+1)'(DEPTH));
  assign count     = count_q;
  assign tail_prev = tail - PW'(1);

  // A simultaneous push and pop is treated as ambiguous and refused outright.
  assign do_push = push && !pop && !full;
  assign do_pop  = pop && !push && !empty;
  assign reject  = (push || pop) && !do_push && !do_pop;

  assign stack_out = empty ? '0 : mem[tail_prev];
  assign queue_out = empty ? '0 : mem[head];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      err     <= 1'b0;
    end else begin
      err <= reject;
      if (do_push) begin
        tail    <= tail + PW'(1);
        count_q <= count_q + (PW+1)'(1);
      end else if (do_pop) begin
        if (stackQueue == MODE_STACK)
          tail <= tail_prev;
        else
          head <= head + PW'(1);
        count_q <= count_q - (PW+1)'(1);
      end
    end
  end

  // Storage is never cleared; a write is suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (do_push && !rst)
      mem[tail] <= data_in;
  end

endmodule

// File: tb/tb_stack_queue_store.sv
// Randomized bench for stack_queue_store against a deque model, plus fixed scenarios.
module tb_stack_queue_store;
  import stack_queue_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             stackQueue = MODE_STACK;
  logic [WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0] stack_out;
  logic [WIDTH-1:0] queue_out;
  logic             empty;
  logic             full;
  logic [4:0]       count;
  logic             err;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  logic [WIDTH-1:0] mq[$];
  logic             exp_err = 1'b0;

  stack_queue_store #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .stackQueue(stackQueue),
    .data_in(data_in), .stack_out(stack_out), .queue_out(queue_out),
    .empty(empty), .full(full), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  // Model: valid entries as a deque; push appends, stack pop drops newest, queue pop drops oldest.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      exp_err <= 1'b0;
    end else if (push && pop) begin
      exp_err <= 1'b1;
    end else if (push) begin
      if (mq.size() == DEPTH) exp_err <= 1'b1;
      else begin
        mq.push_back(data_in);
        exp_err <= 1'b0;
      end
    end else if (pop) begin
      if (mq.size() == 0) exp_err <= 1'b1;
      else begin
        if (stackQueue == MODE_STACK) void'(mq.pop_back());
        else void'(mq.pop_front());
        exp_err <= 1'b0;
      end
    end else begin
      exp_err <= 1'b0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_count", 32'(count), 32'(mq.size()));
      check_output("model_empty", 32'(empty), 32'(mq.size() == 0));
      check_output("model_full", 32'(full), 32'(mq.size() == DEPTH));
      check_output("model_err", 32'(err), 32'(exp_err));
      check_output("model_stack_out", stack_out, (mq.size() == 0) ? 32'h0 : mq[mq.size()-1]);
      check_output("model_queue_out", queue_out, (mq.size() == 0) ? 32'h0 : mq[0]);
    end
  end

  task automatic apply_stimulus(input logic p, input logic q, input logic mode, input logic [WIDTH-1:0] d);
    push       = p;
    pop        = q;
    stackQueue = mode;
    data_in    = d;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    check_output("reset_empty", 32'(empty), 32'd1);
    check_output("reset_full", 32'(full), 32'd0);
    check_output("reset_count", 32'(count), 32'd0);
    check_output("reset_err", 32'(err), 32'd0);
    check_output("reset_stack_out", stack_out, 32'd0);
    check_output("reset_queue_out", queue_out, 32'd0);
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Stack mode: three pushes then one pop
    apply_stimulus(1, 0, MODE_STACK, 32'h5);
    apply_stimulus(1, 0, MODE_STACK, 32'h7);
    apply_stimulus(1, 0, MODE_STACK, 32'h9);
    apply_stimulus(0, 1, MODE_STACK, 32'h0);
    check_output("stk_stack_out", stack_out, 32'h7);
    check_output("stk_count", 32'(count), 32'd2);
    check_output("stk_queue_out", queue_out, 32'h5);

    // Queue mode: same pushes then one pop
    do_reset();
    apply_stimulus(1, 0, MODE_QUEUE, 32'h5);
    apply_stimulus(1, 0, MODE_QUEUE, 32'h7);
    apply_stimulus(1, 0, MODE_QUEUE, 32'h9);
    apply_stimulus(0, 1, MODE_QUEUE, 32'h0);
    check_output("que_queue_out", queue_out, 32'h7);
    check_output("que_stack_out", stack_out, 32'h9);
    check_output("que_count", 32'(count), 32'd2);

    // Fill to capacity, then overflow
    do_reset();
    for (int i = 1; i <= DEPTH; i++) apply_stimulus(1, 0, MODE_STACK, 32'(i));
    check_output("fill_full", 32'(full), 32'd1);
    apply_stimulus(1, 0, MODE_STACK, 32'd17);
    check_output("ovf_err", 32'(err), 32'd1);
    check_output("ovf_count", 32'(count), 32'd16);
    check_output("ovf_stack_out", stack_out, 32'd16);
    check_output("ovf_queue_out", queue_out, 32'd1);
    apply_stimulus(0, 0, MODE_STACK, 32'd0);
    check_output("ovf_err_one_cycle", 32'(err), 32'd0);

    // Underflow and simultaneous push+pop
    do_reset();
    apply_stimulus(0, 1, MODE_QUEUE, 32'd0);
    check_output("udf_err", 32'(err), 32'd1);
    check_output("udf_count", 32'(count), 32'd0);
    apply_stimulus(1, 0, MODE_QUEUE, 32'h3);
    apply_stimulus(1, 1, MODE_QUEUE, 32'h4);
    check_output("both_err", 32'(err), 32'd1);
    check_output("both_count", 32'(count), 32'd1);
    check_output("both_stack_out", stack_out, 32'h3);
    check_output("both_queue_out", queue_out, 32'h3);

    // Queue wrap-around with alternating push/pop, two entries kept in flight
    do_reset();
    apply_stimulus(1, 0, MODE_QUEUE, 32'd100);
    apply_stimulus(1, 0, MODE_QUEUE, 32'd101);
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1, 0, MODE_QUEUE, 32'(200 + i));
      apply_stimulus(0, 1, MODE_QUEUE, 32'd0);
      check_output("wrap_queue_out", queue_out, (i == 0) ? 32'd101 : 32'(200 + i - 1));
      check_output("wrap_count", 32'(count), 32'd2);
    end

    // Randomized traffic with occasional resets and mode flips
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else apply_stimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                          1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset between edges with three entries held
    do_reset();
    apply_stimulus(1, 0, MODE_QUEUE, 32'hA1);
    apply_stimulus(1, 0, MODE_QUEUE, 32'hA2);
    apply_stimulus(1, 0, MODE_QUEUE, 32'hA3);
    check_output("async_pre_count", 32'(count), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_output("async_empty", 32'(empty), 32'd1);
    check_output("async_count", 32'(count), 32'd0);
    check_output("async_stack_out", stack_out, 32'd0);
    check_output("async_queue_out", queue_out, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply_stimulus(0, 0, MODE_QUEUE, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
